// File: rtl/display_pkg.sv
// Shared constants and types for the count display path: segment codes,
// converter state encoding and the double-dabble shift length.
package display_pkg;

  localparam int SHIFT_CYCLES = 8;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_e;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_U     = 7'b1000001;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, 10 cycles per
// conversion; the bcd output only changes on the DONE cycle.
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int BIN_WIDTH  = 8,
  parameter int BCD_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [BIN_WIDTH-1:0]    bin,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] bcd
);

  localparam int CW = $clog2(SHIFT_CYCLES);

  conv_state_e             state, next_state;
  logic [BIN_WIDTH-1:0]    shreg;
  logic [4*BCD_DIGITS-1:0] scratch, adj;
  logic [CW-1:0]           sh_cnt;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SHIFT;
      SHIFT:   if (sh_cnt == CW'(SHIFT_CYCLES - 1)) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign done = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      shreg   <= '0;
      scratch <= '0;
      sh_cnt  <= '0;
      bcd     <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: if (start) begin
          shreg   <= bin;
          scratch <= '0;
          sh_cnt  <= '0;
        end
        SHIFT: begin
          {scratch, shreg} <= {adj[4*BCD_DIGITS-2:0], shreg, 1'b0};
          sh_cnt           <= sh_cnt + 1'b1;
        end
        DONE:    bcd <= scratch;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/count_display_driver.sv
// Shows the counter value (0-255, leading zeros blanked) and its U/d/P
// status on a 4-digit active-low multiplexed seven-segment display.
module count_display_driver
  import display_pkg::*;
#(
  parameter int COUNT_WIDTH = 8,
  parameter int REFRESH_DIV = 5000,
  parameter int BCD_DIGITS  = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [COUNT_WIDTH-1:0] count,
  input  logic                   up,
  input  logic                   enable,
  output logic [6:0]             seg,
  output logic                   dp,
  output logic [3:0]             an
);

  localparam int RW = $clog2(REFRESH_DIV);

  logic [4*BCD_DIGITS-1:0] disp_bcd;
  logic                    conv_done;
  logic                    st_up, st_en;
  logic [RW-1:0]           refresh_cnt;
  logic [1:0]              digit_idx;
  logic [6:0]              seg_next;
  logic [3:0]              an_next;
  logic [3:0]              ones, tens, hundreds;

  bin2bcd_seq #(
    .BIN_WIDTH (COUNT_WIDTH),
    .BCD_DIGITS(BCD_DIGITS)
  ) u_conv (
    .clk  (clk),
    .reset(reset),
    .start(1'b1),
    .bin  (count),
    .done (conv_done),
    .bcd  (disp_bcd)
  );

  assign ones     = disp_bcd[3:0];
  assign tens     = disp_bcd[7:4];
  assign hundreds = disp_bcd[11:8];
  assign dp       = 1'b1;

  always_comb begin
    seg_next = SEG_BLANK;
    an_next  = ~(4'b0001 << digit_idx);
    case (digit_idx)
      2'd0: seg_next = bcd_to_seg(ones);
      2'd1: if (hundreds != 4'd0 || tens != 4'd0) seg_next = bcd_to_seg(tens);
      2'd2: if (hundreds != 4'd0) seg_next = bcd_to_seg(hundreds);
      2'd3: seg_next = !st_en ? SEG_P : (st_up ? SEG_U : SEG_D);
      default: ;
    endcase
  end

  // Status is latched on the same edge the converter publishes its BCD so
  // all four digits always describe one sample.
  always_ff @(posedge clk) begin
    if (!reset) begin
      st_up       <= 1'b0;
      st_en       <= 1'b0;
      refresh_cnt <= '0;
      digit_idx   <= '0;
      seg         <= SEG_BLANK;
      an          <= 4'b1111;
    end else begin
      if (conv_done) begin
        st_up <= up;
        st_en <= enable;
      end
      if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
        refresh_cnt <= '0;
        digit_idx   <= digit_idx + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
      seg <= seg_next;
      an  <= an_next;
    end
  end

endmodule

// File: tb/tb_count_display_driver.sv
// Self-checking bench for count_display_driver against a decimal-arithmetic
// model of what each digit slot should show at every clock edge.
module tb_count_display_driver;

  localparam int DIV  = 4;
  localparam int MAXH = 8192;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] count = 8'd0;
  logic       up = 1'b0;
  logic       enable = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int n = 0;  // edges since reset release; 0 = in/just out of reset
  int hc [MAXH];
  bit hu [MAXH];
  bit he [MAXH];
  logic [6:0] digit_code [10];

  count_display_driver #(
    .COUNT_WIDTH(8),
    .REFRESH_DIV(DIV),
    .BCD_DIGITS (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .count (count),
    .up    (up),
    .enable(enable),
    .seg   (seg),
    .dp    (dp),
    .an    (an)
  );

  always #5 clk = ~clk;

  task automatic tick();
    if (reset) begin
      hc[n+1] = int'(count);
      hu[n+1] = up;
      he[n+1] = enable;
    end
    @(posedge clk);
    if (!reset) n = 0;
    else n++;
    #1;
  endtask

  // A sample is captured on edges 1, 11, 21, ... and published with its
  // status on edges 10, 20, 30, ...; outputs lag by one edge.
  function automatic logic [6:0] exp_seg(int k);
    int j, idx, val, m;
    bit u, e;
    if (k == 0) return 7'b1111111;
    j   = k - 1;
    idx = (j / DIV) % 4;
    if (j < 10) begin
      val = 0; u = 0; e = 0;
    end else begin
      m = j / 10;
      val = hc[10*m - 9];
      u   = hu[10*m];
      e   = he[10*m];
    end
    case (idx)
      0: return digit_code[val % 10];
      1: return (val >= 10) ? digit_code[(val / 10) % 10] : 7'b1111111;
      2: return (val >= 100) ? digit_code[val / 100] : 7'b1111111;
      default: return !e ? 7'b0001100 : (u ? 7'b1000001 : 7'b0100001);
    endcase
  endfunction

  function automatic logic [3:0] exp_an(int k);
    logic [3:0] m;
    if (k == 0) return 4'b1111;
    m = 4'b0001 << (((k - 1) / DIV) % 4);
    return ~m;
  endfunction

  task automatic test_reset();
    reset = 1'b0; count = 8'd0; up = 1'b0; enable = 1'b0;
    repeat (3) begin
      tick();
      total_cnt++;
      if ({an, seg, dp} !== {4'b1111, 7'b1111111, 1'b1})
        $display("FAIL reset_hold: an/seg/dp got %b/%b/%b want 1111/1111111/1", an, seg, dp);
      else pass_cnt++;
    end
    reset = 1'b1;
    tick();
    total_cnt++;
    if (an !== 4'b1110 || seg !== 7'b1000000)
      $display("FAIL reset_first: an/seg got %b/%b want 1110/1000000", an, seg);
    else pass_cnt++;
    repeat (16) begin
      tick();
      total_cnt++;
      if ({an, seg, dp} !== {exp_an(n), exp_seg(n), 1'b1})
        $display("FAIL reset_scan n=%0d: an/seg/dp got %b/%b/%b want %b/%b/1", n, an, seg, dp, exp_an(n), exp_seg(n));
      else pass_cnt++;
    end
    total_cnt++;
    if (an !== 4'b1110)
      $display("FAIL reset_wrap: an got %b want 1110", an);
    else pass_cnt++;
  endtask

  task automatic test_directed(input logic [7:0] c, input logic u, input logic e,
                               input logic [6:0] want [4], input string name);
    count = c; up = u; enable = e;
    repeat (22) begin
      tick();
      total_cnt++;
      if ({an, seg, dp} !== {exp_an(n), exp_seg(n), 1'b1})
        $display("FAIL %s_settle n=%0d: an/seg got %b/%b want %b/%b", name, n, an, seg, exp_an(n), exp_seg(n));
      else pass_cnt++;
    end
    repeat (16) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        if (an == ~(4'b0001 << i)) begin
          total_cnt++;
          if (seg !== want[i])
            $display("FAIL %s_slot%0d: seg got %b want %b", name, i, seg, want[i]);
          else pass_cnt++;
        end
      end
      total_cnt++;
      if (an !== exp_an(n))
        $display("FAIL %s_an n=%0d: an got %b want %b", name, n, an, exp_an(n));
      else pass_cnt++;
    end
  endtask

  task automatic test_mid_change();
    up = 1'b1; enable = 1'b1;
    while (n % 10 != 0) tick();
    count = 8'd100;
    repeat (3) tick();
    count = 8'd42;
    repeat (30) begin
      tick();
      total_cnt++;
      if ({an, seg, dp} !== {exp_an(n), exp_seg(n), 1'b1})
        $display("FAIL mid_change n=%0d: an/seg got %b/%b want %b/%b", n, an, seg, exp_an(n), exp_seg(n));
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_shift();
    count = 8'd200; up = 1'b0; enable = 1'b1;
    while (n % 10 != 4) tick();
    reset = 1'b0;
    tick();
    total_cnt++;
    if ({an, seg, dp} !== {4'b1111, 7'b1111111, 1'b1})
      $display("FAIL mid_reset_off: an/seg/dp got %b/%b/%b want 1111/1111111/1", an, seg, dp);
    else pass_cnt++;
    reset = 1'b1;
    repeat (40) begin
      tick();
      total_cnt++;
      if ({an, seg, dp} !== {exp_an(n), exp_seg(n), 1'b1})
        $display("FAIL mid_reset_run n=%0d: an/seg got %b/%b want %b/%b", n, an, seg, exp_an(n), exp_seg(n));
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    repeat (600) begin
      if ($urandom_range(0, 7) == 0) begin
        count  = 8'($urandom_range(0, 255));
        up     = 1'($urandom_range(0, 1));
        enable = 1'($urandom_range(0, 3) != 0);
      end
      tick();
      total_cnt++;
      if ({an, seg, dp} !== {exp_an(n), exp_seg(n), 1'b1})
        $display("FAIL random n=%0d: an/seg got %b/%b want %b/%b", n, an, seg, exp_an(n), exp_seg(n));
      else pass_cnt++;
    end
  endtask

  initial begin
    digit_code = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                   7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    test_reset();
    test_directed(8'd255, 1'b1, 1'b1,
                  '{7'b0010010, 7'b0010010, 7'b0100100, 7'b1000001}, "c255");
    test_directed(8'd7, 1'b0, 1'b1,
                  '{7'b1111000, 7'b1111111, 7'b1111111, 7'b0100001}, "c7");
    test_directed(8'd0, 1'b1, 1'b0,
                  '{7'b1000000, 7'b1111111, 7'b1111111, 7'b0001100}, "c0");
    test_mid_change();
    test_reset_mid_shift();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/count_display_driver.md
Name: count_display_driver

Overview:
- Display-side consumer of the 8-bit up/down counter value.
- Converts the binary count to BCD with a sequential double-dabble engine.
- Drives a 4-digit, active-low, multiplexed seven-segment display from the same 5 MHz domain that feeds the clock divider.
- Digit 3 shows counter status: U = counting up, d = counting down, P = paused (enable low). Digits 2..0 show 0-255 with leading-zero blanking.

Parameters:
- COUNT_WIDTH, 8: width of count input; fixed at 8 for 3 decimal digits.
- REFRESH_DIV, 5000: clk cycles per digit slot (1 kHz per digit at 5 MHz); must be >= 2.
- BCD_DIGITS, 3: decimal digits produced by the converter.

Ports:
- clk  in  1  system clock (5 MHz); all logic on its rising edge.
- reset  in  1  synchronous, active-low reset.
- count  in  8  binary value to display.
- up  in  1  counter direction, 1 = up.
- enable  in  1  counter enable, 0 = paused.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- dp  out  1  decimal point, active-low, held 1 (off).
- an  out  4  digit anodes, active-low one-cold, registered; an[0] = ones digit.

Behaviour:
- Reset (reset==0 at a clk edge) sets: seg=7'b1111111, an=4'b1111, dp=1, BCD display registers=0, digit index=0, refresh counter=0, converter FSM=IDLE. Reset applied mid-conversion aborts the conversion with no partial result latched.
- Converter FSM:
  - IDLE: captures count into shift register, clears scratch BCD, -> SHIFT.
  - SHIFT: 8 cycles; each cycle add 3 to any BCD nibble >= 5, then shift left one bit.
  - DONE: copies scratch BCD to display registers, -> IDLE.
  - One conversion = 10 cycles, free-running and back-to-back.
  - count changes during a conversion are ignored; the new value is visible in the display registers at most 20 cycles after the change.
- Status latch: up and enable are sampled in DONE alongside the BCD, so digit 3 and digits 2..0 always update together.
- Refresh:
  - refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, digit index increments 0->1->2->3->0.
  - an and seg are registered from the current digit index and display registers: one-cycle latency, no ghosting (an and seg change on the same edge).
- Digit content:
  - idx0: ones digit, always shown.
  - idx1: tens digit; blank if hundreds==0 and tens==0.
  - idx2: hundreds digit; blank if 0.
  - idx3: P if latched enable==0, else U if latched up==1, else d.
- Segment codes (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - U=1000001, d=0100001, P=0001100, blank=1111111.
- First cycle after reset release: an=1110, seg=1000000 (ones shows 0); idx1..2 blank; idx3 shows P until the first DONE latches status.
- BCD nibble values above 9 cannot occur for 8-bit input; the decoder maps them to blank.

Decomposition:
- display_pkg holds:
  - seven-segment constants for digits 0-9, U, d, P and blank;
  - converter state enum (IDLE, SHIFT, DONE);
  - the SHIFT_CYCLES constant (8).
- One natural sub-module, bin2bcd_seq: sequential double-dabble converter with start/done pulses, 8-bit in, 12-bit BCD out. The top keeps refresh, multiplexing and decoding.

Test Plan:
- Reset held 3 cycles, then released, REFRESH_DIV=4: cycle 1 after release gives an=1110, seg=1000000; an steps 1101, 1011, 0111 every 4 cycles and returns to 1110 after 16 cycles.
- count=255, up=1, enable=1, wait 20 cycles: slots show 5,5,2,U (seg 0010010, 0010010, 0100100, 1000001).
- count=7, up=0, enable=1: slots show 7, blank, blank, d (1111000, 1111111, 1111111, 0100001).
- count=0, enable=0: only idx0 shows 0; idx3 shows P (0001100).
- count changed 100->42 at cycle 3 of a conversion: display still shows 100 at cycle 10; shows 42 by cycle 20; no intermediate value ever appears.
- reset asserted during SHIFT with count=200: outputs go to all-off next cycle; after release, 200 is fully converted within 10 cycles and no garbage digit is ever driven.
